mem_stream_reader: RTL and testbench

Master-side read engine for the `MemoryBus`. It issues a run of sequential 32-bit word reads to the DRAM interface stage, keeping up to 2^TAG_BITS reads in flight. Responses may return out of order across IDs; they are realigned through an ID-indexed reorder buffer. The block then presents them as an in-order ready/valid word stream to downstream consumers such as pixel and compute pipelines.

---
 rtl/mem_stream_reader_if.sv | 26 ++
 rtl/mem_stream_reader.sv | 143 ++++++++++++++
 tb/tb_mem_stream_reader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stream_reader_if.sv
// MemoryBus: request/response bus between a read master and the DRAM stage.
//   ms* signals travel master -> slave (request channel, msTaken returns).
//   sm* signals travel slave -> master (response channel, smTaken returns).
//   IDs are 6 bits wide; masters with fewer tag bits leave the upper bits 0.
interface MemoryBus;
  logic        msValid;
  logic [31:0] msAddress;
  logic        msWrite;
  logic [31:0] msData;
  logic [5:0]  msID;
  logic        msTaken;
  logic        smValid;
  logic [31:0] smData;
  logic [5:0]  smID;
  logic        smTaken;

  modport Master (
    output msValid, msAddress, msWrite, msData, msID, smTaken,
    input  msTaken, smValid, smData, smID
  );

  modport Slave (
    input  msValid, msAddress, msWrite, msData, msID, smTaken,
    output msTaken, smValid, smData, smID
  );
endinterface

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: issues a run of sequential word reads on a MemoryBus,
// keeps up to 2^TAG_BITS reads in flight, realigns out-of-order responses in
// a tag-indexed reorder buffer and emits them as an in-order ready/valid stream.
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   start, base, count  - launch a run of `count` words from byte address `base`
//   busy, done          - run in progress / one-cycle completion pulse
//   bus                 - MemoryBus master side (requests out, responses in)
//   outData, outValid   - in-order stream word and its valid
//   outReady            - downstream accept
module mem_stream_reader #(
  parameter int TAG_BITS = 3,
  parameter int STRIDE   = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     base,
  input  logic [15:0]     count,
  output logic            busy,
  output logic            done,
  MemoryBus.Master        bus,
  output logic [31:0]     outData,
  output logic            outValid,
  input  logic            outReady
);

  localparam int DEPTH = 1 << TAG_BITS;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state;
  logic [16:0]           count_q;
  logic [16:0]           i_q;        // issue index
  logic [16:0]           r_q;        // retire index
  logic                  req_valid_q;
  logic [31:0]           addr_q;     // always base + i*STRIDE
  logic [TAG_BITS-1:0]   tag_q;
  logic [31:0]           slot_data [DEPTH];
  logic [DEPTH-1:0]      slot_valid;

  logic                  issue_fire;
  logic                  pop_fire;
  logic [16:0]           i_next;
  logic [16:0]           r_next;
  logic                  can_issue;
  logic [TAG_BITS-1:0]   head;
  logic [TAG_BITS-1:0]   rsp_tag;
  logic [TAG_BITS-1:0]   rsp_off;
  logic                  rsp_accept;

  assign issue_fire = req_valid_q && bus.msTaken;
  assign head       = r_q[TAG_BITS-1:0];
  assign outValid   = slot_valid[head];
  // NOTE: slot_data is never reset, so the read is gated to keep outData at 0
  // whenever nothing valid is being presented.
  assign outData    = outValid ? slot_data[head] : 32'd0;
  assign pop_fire   = outValid && outReady;

  assign i_next = i_q + 17'(issue_fire);
  assign r_next = r_q + 17'(pop_fire);
  // Uses the post-pop retire index, so a freed credit is visible to the
  // request presented right after the pop edge, never in the pop cycle itself.
  assign can_issue = (i_next < count_q) && ((i_next - r_next) < 17'(DEPTH));

  // A tag is in flight when its distance from the head is below i - r.
  // IDs with nonzero bits above the tag field were never issued.
  assign rsp_tag    = bus.smID[TAG_BITS-1:0];
  assign rsp_off    = rsp_tag - head;
  assign rsp_accept = bus.smValid && (state == S_RUN)
                    && ((bus.smID >> TAG_BITS) == 6'd0)
                    && !slot_valid[rsp_tag]
                    && (17'(rsp_off) < (i_q - r_q));

  // Every in-flight tag owns a reserved slot, so responses are never stalled.
  assign bus.smTaken   = bus.smValid && !reset;
  assign bus.msValid   = req_valid_q;
  assign bus.msAddress = addr_q;
  assign bus.msID      = 6'(tag_q);
  assign bus.msWrite   = 1'b0;
  assign bus.msData    = 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      count_q     <= '0;
      i_q         <= '0;
      r_q         <= '0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      tag_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      slot_valid  <= '0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides
      // it, which is how done becomes a single-cycle pulse.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (count != 16'd0) begin
              state       <= S_RUN;
              busy        <= 1'b1;
              count_q     <= {1'b0, count};
              i_q         <= '0;
              r_q         <= '0;
              slot_valid  <= '0;
              req_valid_q <= 1'b1;
              addr_q      <= base;
              tag_q       <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          i_q <= i_next;
          r_q <= r_next;
          if (rsp_accept) slot_valid[rsp_tag] <= 1'b1;
          if (pop_fire)   slot_valid[head]    <= 1'b0;
          // Request fields only move once the current request is taken.
          if (!req_valid_q || bus.msTaken) begin
            req_valid_q <= can_issue;
            tag_q       <= i_next[TAG_BITS-1:0];
          end
          if (issue_fire) addr_q <= addr_q + 32'(STRIDE);
          if (r_next == count_q) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rsp_accept) slot_data[rsp_tag] <= bus.smData;
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader (TAG_BITS=3, STRIDE=4).
module tb_mem_stream_reader;
  localparam int TAG_BITS = 3;
  localparam int DEPTH    = 1 << TAG_BITS;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] run_base;
  logic [15:0] run_count;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  MemoryBus bus_if ();

  mem_stream_reader #(.TAG_BITS(TAG_BITS), .STRIDE(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base     (run_base),
    .count    (run_count),
    .busy     (busy),
    .done     (done),
    .bus      (bus_if),
    .outData  (out_data),
    .outValid (out_valid),
    .outReady (out_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] base;
    int          count;
    bit          stall;      // hold msTaken low 3 cycles on request 2
    bit          toggle;     // outReady pattern 1,0,0,1,...
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_span;   // cycles from first to last request, -1 = unchecked
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  id;
  } req_t;

  int   n_checks = 0;
  int   n_errors = 0;
  req_t pend[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic launch(input logic [31:0] b, input int n);
    run_base  = b;
    run_count = 16'(n);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic issue_until(input int n, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus_if.msValid && bus_if.msTaken) got++;
      step();
    end
  endtask

  // Plays an always-answering slave (in-order responses, data = address)
  // and a sink, checking every request and every stream word.
  task automatic run_vector(input string nm, input vec_t v);
    int          nreq, nwords, ndone, stall_cnt, tail;
    int          first_cyc, last_cyc, last_pop, done_cyc;
    bit          prev_hold, finished;
    logic [31:0] prev_addr, first_addr, last_addr;
    logic [5:0]  prev_id;
    req_t        rq;
    nreq = 0; nwords = 0; ndone = 0; stall_cnt = 0; tail = 0;
    first_cyc = 0; last_cyc = 0; last_pop = -10; done_cyc = -20;
    prev_hold = 1'b0; finished = 1'b0;
    prev_addr = '0; first_addr = 'x; last_addr = 'x; prev_id = '0;
    pend.delete();
    bus_if.msTaken = 1'b1;
    launch(v.base, v.count);
    check({nm, "_busy_after_start"}, busy, 1);
    check({nm, "_req_after_start"}, bus_if.msValid, 1);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      if (pend.size() > 0) begin
        rq = pend.pop_front();
        bus_if.smValid = 1'b1;
        bus_if.smData  = rq.addr;
        bus_if.smID    = rq.id;
      end else begin
        bus_if.smValid = 1'b0;
      end
      out_ready = v.toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      bus_if.msTaken = 1'b1;
      if (v.stall && bus_if.msValid && nreq == 2 && stall_cnt < 3) begin
        bus_if.msTaken = 1'b0;
        stall_cnt++;
      end
      if (prev_hold) begin
        check({nm, "_hold_valid"}, bus_if.msValid, 1);
        check({nm, "_hold_addr"}, bus_if.msAddress, prev_addr);
        check({nm, "_hold_id"}, 32'(bus_if.msID), 32'(prev_id));
      end
      if (bus_if.msValid && bus_if.msTaken) begin
        check($sformatf("%s_req%0d_addr", nm, nreq), bus_if.msAddress, v.base + 32'(nreq * 4));
        check($sformatf("%s_req%0d_id", nm, nreq), 32'(bus_if.msID), 32'(nreq % DEPTH));
        if (nreq == 0) begin
          first_addr = bus_if.msAddress;
          first_cyc  = cyc;
        end
        last_addr = bus_if.msAddress;
        last_cyc  = cyc;
        rq.addr   = bus_if.msAddress;
        rq.id     = bus_if.msID;
        pend.push_back(rq);
        nreq++;
      end
      prev_hold = bus_if.msValid && !bus_if.msTaken;
      prev_addr = bus_if.msAddress;
      prev_id   = bus_if.msID;
      if (out_valid && out_ready) begin
        check($sformatf("%s_word%0d", nm, nwords), out_data, v.base + 32'(nwords * 4));
        nwords++;
        last_pop = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        check({nm, "_busy_at_done"}, busy, 0);
      end
      if (ndone > 0) tail++;
      finished = (tail >= 3);
      step();
    end
    bus_if.smValid = 1'b0;
    out_ready      = 1'b0;
    check({nm, "_finished_in_budget"}, 32'(finished), 1);
    check({nm, "_requests"}, nreq, v.count);
    check({nm, "_words"}, nwords, v.count);
    check({nm, "_done_pulses"}, ndone, 1);
    check({nm, "_done_after_last_pop"}, done_cyc, last_pop + 1);
    check({nm, "_first_addr"}, first_addr, v.exp_first);
    check({nm, "_last_addr"}, last_addr, v.exp_last);
    if (v.exp_span >= 0) check({nm, "_req_span"}, last_cyc - first_cyc, v.exp_span);
  endtask

  initial begin
    vec_t vecs [5];
    vec_t post;
    int   got, nw;
    bit   done_seen;
    int   ooo_order [8];
    int   ooo_exp_valid [8];

    vecs[0] = '{32'h0000_1000, 4,  1'b0, 1'b0, 32'h0000_1000, 32'h0000_100C, 3};
    vecs[1] = '{32'hFFFF_FFFC, 2,  1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1};
    vecs[2] = '{32'h0000_0020, 1,  1'b0, 1'b0, 32'h0000_0020, 32'h0000_0020, 0};
    vecs[3] = '{32'h0000_4000, 10, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_4024, 9};
    vecs[4] = '{32'h0000_8000, 12, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_802C, -1};
    ooo_order     = '{7, 3, 0, 1, 2, 6, 5, 4};
    ooo_exp_valid = '{0, 0, 0, 1, 1, 1, 1, 0};

    // Reset state, with a response on the bus while reset is high.
    reset = 1'b1; start = 1'b0; run_base = '0; run_count = '0; out_ready = 1'b0;
    bus_if.msTaken = 1'b0; bus_if.smValid = 1'b1; bus_if.smData = 32'h1234_5678; bus_if.smID = '0;
    #2;
    check("rst_msValid", bus_if.msValid, 0);
    check("rst_msAddress", bus_if.msAddress, 0);
    check("rst_msID", 32'(bus_if.msID), 0);
    check("rst_msWrite", bus_if.msWrite, 0);
    check("rst_msData", bus_if.msData, 0);
    check("rst_outValid", out_valid, 0);
    check("rst_outData", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_smTaken", bus_if.smTaken, 0);
    bus_if.smValid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    step();

    // Table-driven runs.
    for (int k = 0; k < 5; k++) run_vector($sformatf("vec%0d", k), vecs[k]);

    // Empty run.
    launch(32'h0000_9000, 0);
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    check("empty_msValid", bus_if.msValid, 0);
    step();
    check("empty_done_cleared", done, 0);
    check("empty_msValid_later", bus_if.msValid, 0);

    // Out-of-order responses.
    bus_if.msTaken = 1'b1;
    out_ready      = 1'b1;
    launch(32'h0000_2000, 8);
    issue_until(100, 20, got);
    check("ooo_requests", got, 8);
    check("ooo_no_more_req", bus_if.msValid, 0);
    nw = 0;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("ooo_valid_%0d", j), out_valid, 32'(ooo_exp_valid[j]));
      if (out_valid) begin
        check($sformatf("ooo_word%0d", nw), out_data, 32'h0000_2000 + 32'(nw * 4));
        nw++;
      end
      bus_if.smValid = 1'b1;
      bus_if.smID    = 6'(ooo_order[j]);
      bus_if.smData  = 32'h0000_2000 + 32'(ooo_order[j] * 4);
      step();
    end
    bus_if.smValid = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (out_valid) begin
        check($sformatf("ooo_word%0d", nw), out_data, 32'h0000_2000 + 32'(nw * 4));
        nw++;
      end
      if (done) done_seen = 1'b1;
      else step();
    end
    check("ooo_words", nw, 8);
    check("ooo_done", 32'(done_seen), 1);
    step();

    // Credit limit: 8 requests, then one released credit lets tag 0 reissue.
    launch(32'h0000_3000, 20);
    issue_until(100, 15, got);
    check("credit_requests", got, 8);
    check("credit_stalled", bus_if.msValid, 0);
    bus_if.smValid = 1'b1; bus_if.smID = 6'd0; bus_if.smData = 32'h0000_3000;
    step();
    bus_if.smValid = 1'b0;
    check("credit_out_valid", out_valid, 1);
    check("credit_out_data", out_data, 32'h0000_3000);
    check("credit_no_same_cycle_issue", bus_if.msValid, 0);
    step();
    check("credit_9th_valid", bus_if.msValid, 1);
    check("credit_9th_id", 32'(bus_if.msID), 0);
    check("credit_9th_addr", bus_if.msAddress, 32'h0000_3020);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Duplicate response to an already-valid tag is dropped.
    bus_if.msTaken = 1'b1;
    out_ready      = 1'b0;
    launch(32'h0000_5000, 2);
    issue_until(2, 10, got);
    check("dup_requests", got, 2);
    bus_if.smValid = 1'b1; bus_if.smID = 6'd0; bus_if.smData = 32'hAAAA_0000;
    step();
    bus_if.smData = 32'hBBBB_0000;
    step();
    bus_if.smID = 6'd1; bus_if.smData = 32'h0000_5004;
    step();
    bus_if.smValid = 1'b0;
    check("dup_head_valid", out_valid, 1);
    check("dup_head_data", out_data, 32'hAAAA_0000);
    out_ready = 1'b1;
    step();
    check("dup_second_data", out_data, 32'h0000_5004);
    step();
    check("dup_done", done, 1);
    check("dup_out_valid_after", out_valid, 0);
    out_ready = 1'b0;
    step();

    // Reset mid-run.
    launch(32'h0000_6000, 10);
    issue_until(3, 10, got);
    check("mid_requests", got, 3);
    bus_if.msTaken = 1'b0;
    bus_if.smValid = 1'b1; bus_if.smID = 6'd0; bus_if.smData = 32'h0000_6000;
    step();
    check("mid_pre_out_valid", out_valid, 1);
    bus_if.smID = 6'd1; bus_if.smData = 32'h0000_DEAD;
    reset = 1'b1;
    #1;
    check("mid_msValid", bus_if.msValid, 0);
    check("mid_msAddress", bus_if.msAddress, 0);
    check("mid_msID", 32'(bus_if.msID), 0);
    check("mid_outValid", out_valid, 0);
    check("mid_outData", out_data, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_smTaken_in_reset", bus_if.smTaken, 0);
    step();
    reset = 1'b0;
    #1;
    check("stale_smTaken", bus_if.smTaken, 1);
    step();
    bus_if.smValid = 1'b0;
    check("stale_no_output", out_valid, 0);
    check("stale_not_busy", busy, 0);
    check("stale_no_request", bus_if.msValid, 0);
    post = '{32'h0000_7000, 5, 1'b0, 1'b0, 32'h0000_7000, 32'h0000_7010, 4};
    run_vector("post_reset", post);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
